generate_6_bit_sequence_using_fsm: RTL



---
 rtl/generate_6_bit_sequence_using_fsm_if.sv | 26 ++
 rtl/generate_6_bit_sequence_using_fsm.sv | 130 +++++++++++++
 2 files changed

// File: rtl/generate_6_bit_sequence_using_fsm_if.sv
// Control/data bundle for the 6-bit sequence transmitter.
// master drives burst requests; slave is the transmitter.
interface generate_6_bit_sequence_using_fsm_if #(
  parameter int REP_W = 4,
  parameter int GAP_W = 3
);
  logic             start;
  logic             start_ready;
  logic [REP_W-1:0] repeats;
  logic [GAP_W-1:0] gap_len;
  logic             abort;
  logic             a;
  logic             a_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, repeats, gap_len, abort,
    input  start_ready, a, a_valid, busy, done
  );

  modport slave (
    input  start, repeats, gap_len, abort,
    output start_ready, a, a_valid, busy, done
  );
endinterface

// File: rtl/generate_6_bit_sequence_using_fsm.sv
// Moore FSM that serializes PATTERN MSB-first, repeated with zero gaps.
// Outputs are registered from the next-state decode.
module generate_6_bit_sequence_using_fsm #(
  parameter int                   PATTERN_W = 6,
  parameter logic [PATTERN_W-1:0] PATTERN   = 6'b110011,
  parameter int                   REP_W     = 4,
  parameter int                   GAP_W     = 3
) (
  input logic clk,
  input logic rst,
  generate_6_bit_sequence_using_fsm_if.slave bus
);

  localparam int IDX_W = $clog2(PATTERN_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PATTERN_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [REP_W-1:0] r_reps;
  logic [GAP_W-1:0] r_gcnt;
  logic [GAP_W-1:0] r_gap;
  logic             r_a;
  logic             r_a_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_start_ready;

  state_t           w_state;
  logic [IDX_W-1:0] w_idx;
  logic [REP_W-1:0] w_reps;
  logic [GAP_W-1:0] w_gcnt;
  logic [GAP_W-1:0] w_gap;

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_reps  = r_reps;
    w_gcnt  = r_gcnt;
    w_gap   = r_gap;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_gap  = bus.gap_len;
          w_reps = bus.repeats;
          w_idx  = IDX_TOP;
          if (bus.repeats == '0) w_state = DONE;
          else                   w_state = SEND;
        end
      end
      SEND: begin
        if (bus.abort) begin
          w_state = IDLE;
          w_idx   = IDX_TOP;
          w_reps  = '0;
          w_gcnt  = '0;
          w_gap   = '0;
        end else if (r_idx != '0) begin
          w_idx = r_idx - IDX_W'(1);
        end else begin
          w_reps = r_reps - REP_W'(1);
          w_idx  = IDX_TOP;
          if (r_reps == REP_W'(1)) begin
            w_state = DONE;
          end else if (r_gap != '0) begin
            w_state = GAP;
            w_gcnt  = r_gap - GAP_W'(1);
          end
        end
      end
      GAP: begin
        if (bus.abort) begin
          w_state = IDLE;
          w_idx   = IDX_TOP;
          w_reps  = '0;
          w_gcnt  = '0;
          w_gap   = '0;
        end else if (r_gcnt == '0) begin
          w_state = SEND;
          w_idx   = IDX_TOP;
        end else begin
          w_gcnt = r_gcnt - GAP_W'(1);
        end
      end
      DONE: begin
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_idx         <= IDX_TOP;
      r_reps        <= '0;
      r_gcnt        <= '0;
      r_gap         <= '0;
      r_a           <= 1'b0;
      r_a_valid     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_start_ready <= 1'b1;
    end else begin
      r_state       <= w_state;
      r_idx         <= w_idx;
      r_reps        <= w_reps;
      r_gcnt        <= w_gcnt;
      r_gap         <= w_gap;
      r_a           <= (w_state == SEND) && PATTERN[w_idx];
      r_a_valid     <= (w_state == SEND) || (w_state == GAP);
      r_busy        <= (w_state == SEND) || (w_state == GAP);
      r_done        <= (w_state == DONE);
      r_start_ready <= (w_state == IDLE);
    end
  end

  assign bus.a           = r_a;
  assign bus.a_valid     = r_a_valid;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.start_ready = r_start_ready;

endmodule
